// File: rtl/fft_stream_framer_if.sv
// Avalon-ST sink bus between the framer (master) and the FFT core input (slave).
interface fft_stream_framer_if #(
  parameter int DATA_W = 24
);
  logic              sink_valid;
  logic              sink_sop;
  logic              sink_eop;
  logic [DATA_W-1:0] sink_real;
  logic [DATA_W-1:0] sink_imag;
  logic              fft_ready;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
    input  fft_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
    output fft_ready
  );
endinterface

// File: rtl/fft_stream_framer.sv
// Buffers strobed audio samples in a FIFO and emits them as FFT frames of 2^L beats
// on an Avalon-ST sink, with a one-entry output register honouring fft_ready.
module fft_stream_framer #(
  parameter int DATA_W     = 24,
  parameter int LOG2_MIN   = 6,
  parameter int LOG2_MAX   = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          MCLK,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_strobe,
  input  logic                          enable,
  input  logic [3:0]                    len_log2,
  fft_stream_framer_if.master           snk,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              frame_count,
  output logic [CNT_W-1:0]              drop_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LVW = AW + 1;
  localparam int LW  = LOG2_MAX + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LVW-1:0] level, level_nxt;
  logic           full_q;
  logic [0:0]     state;
  logic [LW-1:0]  beat_cnt, last_idx, ld_idx, start_last;
  logic [3:0]     clamp_l;
  beat_t          obeat;
  logic           ovld;

  logic xfer, fifo_empty, push, drop, start, reload, pop, eop_done;

  always_comb begin
    clamp_l = len_log2;
    if (len_log2 < 4'(LOG2_MIN))      clamp_l = 4'(LOG2_MIN);
    else if (len_log2 > 4'(LOG2_MAX)) clamp_l = 4'(LOG2_MAX);
  end

  assign start_last = LW'((32'd1 << clamp_l) - 32'd1);

  assign xfer       = ovld && snk.fft_ready;
  assign fifo_empty = (level == '0);
  // Full is the registered flag, so a strobe while full drops even if a pop happens now.
  assign push       = sample_strobe && !full_q;
  assign drop       = sample_strobe && full_q;
  assign start      = (state == S_IDLE) && enable && !fifo_empty && !ovld;
  // Once the eop beat is loaded, nothing more is taken for this frame.
  assign reload     = (state == S_STREAM) && !fifo_empty && (!ovld || xfer) &&
                      !(ovld && obeat.eop);
  assign pop        = start || reload;
  assign eop_done   = xfer && obeat.eop;
  // Index of the beat being loaded: the register either is empty or hands off beat_cnt now.
  assign ld_idx     = beat_cnt + LW'(xfer);
  assign level_nxt  = level + LVW'(push) - LVW'(pop);

  always_ff @(posedge MCLK) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      full_q      <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      frame_count <= '0;
      state       <= S_IDLE;
      beat_cnt    <= '0;
      last_idx    <= '0;
      ovld        <= 1'b0;
      obeat       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level  <= level_nxt;
      full_q <= (level_nxt == LVW'(FIFO_DEPTH));

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end

      if (start) begin
        state    <= S_STREAM;
        last_idx <= start_last;
        beat_cnt <= '0;
        ovld     <= 1'b1;
        obeat    <= '{sop: 1'b1, eop: (start_last == '0), data: mem[rd_ptr]};
      end else if (state == S_STREAM) begin
        if (xfer) beat_cnt <= beat_cnt + 1'b1;
        if (reload) begin
          ovld  <= 1'b1;
          obeat <= '{sop: 1'b0, eop: (ld_idx == last_idx), data: mem[rd_ptr]};
        end else if (xfer) begin
          ovld <= 1'b0;
        end
        if (eop_done) begin
          state       <= S_IDLE;
          frame_count <= frame_count + 1'b1;
        end
      end
    end
  end

  assign snk.sink_valid = ovld;
  assign snk.sink_sop   = obeat.sop;
  assign snk.sink_eop   = obeat.eop;
  assign snk.sink_real  = obeat.data;
  assign snk.sink_imag  = '0;
  assign busy           = (state == S_STREAM);
  assign fifo_level     = level;
endmodule
